// File: rtl/cpu_bridge_cmd_master.sv
// CPU-domain master that turns the single-outstanding CPU bus into the
// level-request / ack-pulse handshake of the bridge command handler.
module cpu_bridge_cmd_master #(
    parameter int GUARD_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int POSTED_WRITES  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_bus_valid,
    output logic        o_bus_ready,
    input  logic [31:0] i_bus_addr,
    input  logic [31:0] i_bus_wdata,
    input  logic [3:0]  i_bus_wstrb,
    output logic [31:0] o_bus_rdata,
    output logic        o_cpu_req,
    output logic [31:0] o_cpu_addr,
    output logic [31:0] o_cpu_wdata,
    output logic [3:0]  o_cpu_wstrb,
    input  logic        i_cpu_ack_pulse,
    input  logic [31:0] i_cpu_rdata,
    input  logic        i_err_clr,
    output logic        o_timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GUARD_LOAD   = GW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, GUARD} state_t;

    state_t        state_q;
    logic          cpuReq_q;
    logic          busReady_q;
    logic          timeoutErr_q;
    logic          posted_q;
    logic [31:0]   cpuAddr_q;
    logic [31:0]   cpuWdata_q;
    logic [3:0]    cpuWstrb_q;
    logic [31:0]   busRdata_q;
    logic [TW-1:0] timeoutCnt_q;
    logic [GW-1:0] guardCnt_q;
    logic          posted_d;

    // Any non-zero strobe is a write; partial strobes are posted too and left to the handler.
    assign posted_d = (POSTED_WRITES != 0) && (i_bus_wstrb != 4'b0000);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cpuReq_q     <= 1'b0;
            busReady_q   <= 1'b0;
            timeoutErr_q <= 1'b0;
            posted_q     <= 1'b0;
            cpuAddr_q    <= '0;
            cpuWdata_q   <= '0;
            cpuWstrb_q   <= '0;
            busRdata_q   <= '0;
            timeoutCnt_q <= '0;
            guardCnt_q   <= '0;
        end else begin
            busReady_q <= 1'b0;
            if (i_err_clr) begin
                timeoutErr_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (i_bus_valid) begin
                        cpuAddr_q    <= i_bus_addr;
                        cpuWdata_q   <= i_bus_wdata;
                        cpuWstrb_q   <= i_bus_wstrb;
                        cpuReq_q     <= 1'b1;
                        timeoutCnt_q <= '0;
                        posted_q     <= posted_d;
                        busReady_q   <= posted_d;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    // An ack landing on the final timeout cycle still completes normally.
                    if (i_cpu_ack_pulse) begin
                        busRdata_q <= i_cpu_rdata;
                        busReady_q <= !posted_q;
                        cpuReq_q   <= 1'b0;
                        guardCnt_q <= GUARD_LOAD;
                        state_q    <= GUARD;
                    end else if (timeoutCnt_q == TIMEOUT_LAST) begin
                        cpuReq_q     <= 1'b0;
                        timeoutErr_q <= 1'b1;
                        if (!posted_q) begin
                            busRdata_q <= 32'hFFFF_FFFF;
                            busReady_q <= 1'b1;
                        end
                        guardCnt_q <= GUARD_LOAD;
                        state_q    <= GUARD;
                    end else begin
                        timeoutCnt_q <= timeoutCnt_q + TW'(1);
                    end
                end
                GUARD: begin
                    if (guardCnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        guardCnt_q <= guardCnt_q - GW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_bus_ready   = busReady_q;
    assign o_bus_rdata   = busRdata_q;
    assign o_cpu_req     = cpuReq_q;
    assign o_cpu_addr    = cpuAddr_q;
    assign o_cpu_wdata   = cpuWdata_q;
    assign o_cpu_wstrb   = cpuWstrb_q;
    assign o_timeout_err = timeoutErr_q;

endmodule

// File: doc/cpu_bridge_cmd_master.md
# cpu_bridge_cmd_master

CPU-clock-domain master that turns the soft CPU's single-outstanding memory bus into the level-request / ack-pulse crossing handshake of the bridge command handler, i.e. the target-command mailbox at 0xF8xx10xx. It sits directly upstream of the command handler, in the CPU clock domain.
- Drives the request and its address, write data and strobes.
- Waits for the synchronized ack pulse and returns read data.
- Enforces a guard interval so each request edge is seen by the handler.
- Posts writes and reports lost handshakes through a sticky timeout flag.

## Interface
Parameters:
- GUARD_CYCLES, 8: cycles o_cpu_req is held low after a transaction before the next may start; minimum 4.
- TIMEOUT_CYCLES, 1024: cycles waiting for ack before abandoning.
- POSTED_WRITES, 1: 1 = writes complete on the bus at acceptance; 0 = writes wait for ack like reads.

Ports:
- clk  in  1  CPU clock; same clock as the handler's CPU-side clock input.
- reset  in  1  asynchronous, active-high reset.
- i_bus_valid  in  1  CPU request; held with address and data until o_bus_ready.
- o_bus_ready  out  1  one-cycle completion pulse.
- i_bus_addr  in  32  word address; only [7:0] is meaningful downstream.
- i_bus_wdata  in  32  write data.
- i_bus_wstrb  in  4  byte strobes; 0 = read.
- o_bus_rdata  out  32  read data; valid when o_bus_ready is high.
- o_cpu_req  out  1  level request to the handler.
- o_cpu_addr  out  32  held stable while o_cpu_req is high.
- o_cpu_wdata  out  32  held stable while o_cpu_req is high.
- o_cpu_wstrb  out  4  held stable while o_cpu_req is high.
- i_cpu_ack_pulse  in  1  one-cycle ack, already synchronized into clk.
- i_cpu_rdata  in  32  handler read data; stable at the ack pulse.
- i_err_clr  in  1  clears o_timeout_err.
- o_timeout_err  out  1  sticky; set on any abandoned transaction.

## Operation
- FSM states: IDLE, REQ, GUARD.
- IDLE, i_bus_valid=1:
  - Latch addr, wdata and wstrb into the o_cpu_* registers.
  - Set o_cpu_req; clear the timeout counter; go to REQ.
  - If wstrb≠0 and POSTED_WRITES=1, pulse o_bus_ready on the next cycle.
- REQ, i_cpu_ack_pulse=1:
  - o_bus_rdata <= i_cpu_rdata.
  - Pulse o_bus_ready, unless this is a write already posted.
  - o_cpu_req <= 0; load the guard counter; go to GUARD.
- REQ, counter reaches TIMEOUT_CYCLES-1 with no ack:
  - o_cpu_req <= 0; o_timeout_err <= 1.
  - For a non-posted transaction: o_bus_rdata <= 32'hFFFF_FFFF and pulse o_bus_ready.
  - Go to GUARD.
- GUARD: count down GUARD_CYCLES with req low, then go to IDLE.
- Outside REQ: bus requests stall with o_bus_ready=0; a new transaction is accepted only in IDLE.
- Strobes other than 4'b0000 and 4'b1111 are forwarded unchanged. The handler treats them as reads with the write dropped; this block does not filter them.
- i_cpu_ack_pulse in IDLE or GUARD is a stray and is ignored; no state, data or error change.
- Simultaneous events:
  - Ack on the timeout cycle: the ack wins and there is no error.
  - i_err_clr together with a timeout: the set wins.

## Timing
- Reset (asynchronous, and mid-transaction):
  - State IDLE; all outputs 0, including o_cpu_req, o_bus_ready, o_bus_rdata, o_cpu_addr/wdata/wstrb and o_timeout_err.
  - A late ack arriving after reset is a stray and is ignored.
- Acceptance at edge T: o_cpu_req=1 from T+1; a posted write's o_bus_ready is high during T+1 only.
- Ack seen at edge A:
  - o_bus_ready and o_bus_rdata valid during A+1.
  - o_cpu_req low from A+1.
  - Earliest next acceptance at A+1+GUARD_CYCLES.
- Timeout: o_cpu_req has been high for TIMEOUT_CYCLES cycles when it drops; o_timeout_err rises in the same cycle.
- Throughput: at most one transaction per (handshake latency + GUARD_CYCLES + 1) cycles.

## Test plan
- Read, addr 0x40, bench acks 6 cycles after req with rdata 0x12345678:
  - o_bus_ready is a single pulse the cycle after the ack, with o_bus_rdata=0x12345678.
  - req low for exactly 8 cycles afterwards.
- Posted write, addr 0x0, data 0x636D0140, strb 4'b1111:
  - ready at T+1 while req stays high; o_cpu_* stable until the ack.
- Back-to-back write then read:
  - The read stalls with ready=0 until 8 cycles after the write's ack, then completes normally.
- No ack, TIMEOUT_CYCLES=16:
  - req drops after 16 cycles, o_timeout_err=1, a non-posted read returns 0xFFFF_FFFF.
  - i_err_clr clears the flag; i_err_clr on the same cycle as a new timeout leaves it 1.
- Stray ack pulses in IDLE and in GUARD: no bus ready and no change to rdata or state.
- Reset asserted mid-REQ:
  - All outputs read 0 immediately (asynchronous).
  - The subsequent late ack is ignored, and the next read completes correctly.
